// File: rtl/ht_stream_controller.sv
// Sequences one frame through the 27-tap Hilbert transform:
// enable -> coefficient-load wait -> stream samples -> flush -> stop.
// Output Re/Im pairs are re-timed and strobed only for accepted samples.
// Ports:
//   clock, reset             : clock, synchronous active-high reset
//   start, frameLength       : frame start pulse and frame length (latched)
//   sampleIn/Valid/Ready     : upstream valid/ready sample source
//   htEnable, htStopDataInFlag, htDataIn : drive to the transform
//   htDataOutRe/Im           : transform outputs
//   dataOutRe/Im/Valid       : re-timed outputs, one strobe per accepted sample
//   busy, done               : status (done is sticky until reset)
module ht_stream_controller #(
  parameter int unsigned DATA_WIDTH        = 18,
  parameter int unsigned LENGTH            = 27,
  parameter int unsigned COEFF_WAIT_CYCLES = LENGTH + 4,
  parameter int unsigned OUT_LATENCY       = 4,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    frameLength,
  input  logic [DATA_WIDTH-1:0]   sampleIn,
  input  logic                    sampleValid,
  output logic                    sampleReady,
  output logic                    htEnable,
  output logic                    htStopDataInFlag,
  output logic [DATA_WIDTH-1:0]   htDataIn,
  input  logic [2*DATA_WIDTH-1:0] htDataOutRe,
  input  logic [2*DATA_WIDTH-1:0] htDataOutIm,
  output logic [2*DATA_WIDTH-1:0] dataOutRe,
  output logic [2*DATA_WIDTH-1:0] dataOutIm,
  output logic                    dataOutValid,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned OUT_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned TAG_DEPTH = OUT_LATENCY + 1;

  typedef enum logic [2:0] {
    IDLE, COEFF_WAIT, STREAM, FLUSH, STOP, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   frame_len_q, frame_len_d;
  logic [CNT_WIDTH-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
  logic [TAG_DEPTH-1:0]   tag_q, tag_d;
  logic                   ht_enable_q, ht_enable_d;
  logic                   ht_stop_q, ht_stop_d;
  logic [DATA_WIDTH-1:0]  ht_data_q, ht_data_d;
  logic [OUT_WIDTH-1:0]   out_re_q, out_re_d;
  logic [OUT_WIDTH-1:0]   out_im_q, out_im_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   accept;

  // A sample is consumed whenever the source is valid while streaming.
  assign accept = (state_q == STREAM) && sampleValid;

  // Next-state, counters, tag pipe and output stage.
  always_comb begin
    state_d     = state_q;
    frame_len_d = frame_len_q;
    acc_cnt_d   = acc_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    ht_stop_d   = ht_stop_q;
    ht_data_d   = '0;
    // Tags track which transform inputs are real samples vs bubbles.
    tag_d       = {tag_q[TAG_DEPTH-2:0], accept};

    case (state_q)
      IDLE: begin
        if (start && (frameLength != '0)) begin
          state_d     = COEFF_WAIT;
          frame_len_d = frameLength;
          acc_cnt_d   = '0;
          wait_cnt_d  = CNT_WIDTH'(COEFF_WAIT_CYCLES);
        end
      end
      COEFF_WAIT: begin
        if (wait_cnt_q == '0) state_d = STREAM;
        else                  wait_cnt_d = wait_cnt_q - CNT_WIDTH'(1);
      end
      STREAM: begin
        if (sampleValid) begin
          ht_data_d = sampleIn;
          acc_cnt_d = acc_cnt_q + CNT_WIDTH'(1);
          if (acc_cnt_q == frame_len_q - CNT_WIDTH'(1)) begin
            state_d    = FLUSH;
            wait_cnt_d = CNT_WIDTH'(OUT_LATENCY);
          end
        end
      end
      FLUSH: begin
        if (wait_cnt_q == '0) state_d = STOP;
        else                  wait_cnt_d = wait_cnt_q - CNT_WIDTH'(1);
      end
      STOP: begin
        ht_stop_d = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        // Transform stop is terminal; only reset leaves this state.
      end
      default: state_d = IDLE;
    endcase

    ht_enable_d = (state_d != IDLE);
    busy_d      = (state_d == COEFF_WAIT) || (state_d == STREAM) ||
                  (state_d == FLUSH) || (state_d == STOP);
    done_d      = done_q || (state_d == DONE);

    out_valid_d = tag_q[TAG_DEPTH-1];
    out_re_d    = tag_q[TAG_DEPTH-1] ? htDataOutRe : '0;
    out_im_d    = tag_q[TAG_DEPTH-1] ? htDataOutIm : '0;
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_len_q <= '0;
      acc_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      tag_q       <= '0;
      ht_enable_q <= 1'b0;
      ht_stop_q   <= 1'b0;
      ht_data_q   <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_len_q <= frame_len_d;
      acc_cnt_q   <= acc_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      tag_q       <= tag_d;
      ht_enable_q <= ht_enable_d;
      ht_stop_q   <= ht_stop_d;
      ht_data_q   <= ht_data_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sampleReady      = (state_q == STREAM);
  assign htEnable         = ht_enable_q;
  assign htStopDataInFlag = ht_stop_q;
  assign htDataIn         = ht_data_q;
  assign dataOutRe        = out_re_q;
  assign dataOutIm        = out_im_q;
  assign dataOutValid     = out_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_ht_stream_controller.sv
module tb_ht_stream_controller;

  logic        clock = 1'b0;
  logic        reset, start, sampleValid;
  logic [15:0] frameLength;
  logic [17:0] sampleIn;
  logic        sampleReady, htEnable, htStopDataInFlag;
  logic [17:0] htDataIn;
  logic [35:0] htDataOutRe, htDataOutIm, dataOutRe, dataOutIm;
  logic        dataOutValid, busy, done;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int cyc = 0;

  ht_stream_controller dut (
    .clock(clock), .reset(reset), .start(start), .frameLength(frameLength),
    .sampleIn(sampleIn), .sampleValid(sampleValid), .sampleReady(sampleReady),
    .htEnable(htEnable), .htStopDataInFlag(htStopDataInFlag), .htDataIn(htDataIn),
    .htDataOutRe(htDataOutRe), .htDataOutIm(htDataOutIm),
    .dataOutRe(dataOutRe), .dataOutIm(dataOutIm), .dataOutValid(dataOutValid),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [35:0] re_of(input logic [17:0] d);
    return {d, d};
  endfunction
  function automatic logic [35:0] im_of(input logic [17:0] d);
    return {~d, d};
  endfunction

  // Stand-in transform: output updates 4 cycles after htDataIn updates.
  logic [17:0] d1, d2, d3;
  always @(posedge clock) begin
    d1 <= htDataIn;
    d2 <= d1;
    d3 <= d2;
    htDataOutRe <= re_of(d3);
    htDataOutIm <= im_of(d3);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({sampleReady, htEnable, htStopDataInFlag, busy, done, dataOutValid,
                 htDataIn, dataOutRe, dataOutIm});
  endfunction

  // Scoreboard: every accepted sample must strobe out 5 edges later with its data.
  typedef struct { int edge_n; logic [17:0] d; } exp_t;
  exp_t exp_q[$];
  always @(negedge clock) begin
    exp_t e;
    if (dataOutValid === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("pulse_edge", 128'(cyc), 128'(e.edge_n));
        check("pulse_re", dataOutRe, re_of(e.d));
        check("pulse_im", dataOutIm, im_of(e.d));
      end
    end
    if (reset === 1'b1) exp_q.delete();
    else if (sampleReady === 1'b1 && sampleValid === 1'b1)
      exp_q.push_back('{cyc + 6, sampleIn});
  end

  typedef struct {
    logic        v;
    logic [17:0] d;
    logic        st;
    logic [17:0] exp_din;
    logic        exp_rdy;
    logic        exp_dov;
    logic [17:0] exp_src;
  } vec_t;
  vec_t vecs[13];

  task automatic wait_ready(input string name);
    int n = 0;
    while (sampleReady !== 1'b1 && n < 100) begin tick(); n++; end
    check(name, 128'(n < 100), 1);
  endtask

  initial begin
    int n, r, p0;
    vecs[0]  = '{1'b1, 18'h00101, 1'b0, 18'h00101, 1'b1, 1'b0, 18'h0};
    vecs[1]  = '{1'b0, 18'h3FFFF, 1'b0, 18'h00000, 1'b1, 1'b0, 18'h0};
    vecs[2]  = '{1'b0, 18'h00000, 1'b1, 18'h00000, 1'b1, 1'b0, 18'h0};
    vecs[3]  = '{1'b1, 18'h2A5A5, 1'b0, 18'h2A5A5, 1'b1, 1'b0, 18'h0};
    vecs[4]  = '{1'b1, 18'h00007, 1'b0, 18'h00007, 1'b1, 1'b0, 18'h0};
    vecs[5]  = '{1'b0, 18'h15555, 1'b0, 18'h00000, 1'b1, 1'b1, 18'h00101};
    vecs[6]  = '{1'b1, 18'h1FFFF, 1'b0, 18'h1FFFF, 1'b0, 1'b0, 18'h0};
    vecs[7]  = '{1'b1, 18'h12345, 1'b0, 18'h00000, 1'b0, 1'b0, 18'h0};
    vecs[8]  = '{1'b0, 18'h00000, 1'b0, 18'h00000, 1'b0, 1'b1, 18'h2A5A5};
    vecs[9]  = '{1'b0, 18'h00000, 1'b0, 18'h00000, 1'b0, 1'b1, 18'h00007};
    vecs[10] = '{1'b0, 18'h00000, 1'b0, 18'h00000, 1'b0, 1'b0, 18'h0};
    vecs[11] = '{1'b0, 18'h00000, 1'b0, 18'h00000, 1'b0, 1'b1, 18'h1FFFF};
    vecs[12] = '{1'b0, 18'h00000, 1'b0, 18'h00000, 1'b0, 1'b0, 18'h0};

    // Reset then idle
    reset = 1'b1; start = 1'b0; frameLength = '0; sampleIn = '0; sampleValid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check("idle_outputs_zero", all_outs(), 0);
      tick();
    end

    // Start with zero length is ignored
    start = 1'b1; frameLength = 16'd0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("zero_len_busy", busy, 0);
    check("zero_len_enable", htEnable, 0);

    // Basic frame of 8 continuous samples 1..8
    frameLength = 16'd8; start = 1'b1; sampleValid = 1'b1; sampleIn = 18'd1;
    tick();
    start = 1'b0;
    check("start_enable", htEnable, 1);
    check("start_busy", busy, 1);
    check("start_not_ready", sampleReady, 0);
    n = 0;
    while (sampleReady !== 1'b1 && n < 100) begin tick(); n++; end
    check("ready_latency", 128'(n), 32);
    p0 = pulses;
    r = 0;
    while (sampleReady === 1'b1 && r < 100) begin
      tick();
      sampleIn = sampleIn + 18'd1;
      r++;
    end
    check("ready_cycles", 128'(r), 8);
    sampleValid = 1'b0;
    n = 0;
    while (htStopDataInFlag !== 1'b1 && n < 50) begin tick(); n++; end
    check("stop_latency", 128'(n), 6);
    check("frame_done", done, 1);
    check("frame_not_busy", busy, 0);
    check("frame_enable_held", htEnable, 1);
    check("frame_pulses", 128'(pulses - p0), 8);
    check("frame_queue_empty", 128'(exp_q.size()), 0);

    // Start in DONE is ignored
    start = 1'b1; frameLength = 16'd5;
    repeat (3) tick();
    start = 1'b0;
    check("done_start_state", 128'({done, busy, sampleReady, htStopDataInFlag, htEnable}), 128'(5'b10011));

    // Bubbles, with a start pulse during STREAM
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_clears_all", all_outs(), 0);
    frameLength = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready("bubble_ready_reached");
    p0 = pulses;
    for (int i = 0; i < 13; i++) begin
      sampleValid = vecs[i].v; sampleIn = vecs[i].d; start = vecs[i].st;
      tick();
      check($sformatf("vec%0d_din", i), htDataIn, vecs[i].exp_din);
      check($sformatf("vec%0d_ready", i), sampleReady, vecs[i].exp_rdy);
      check($sformatf("vec%0d_dov", i), dataOutValid, vecs[i].exp_dov);
      check($sformatf("vec%0d_re", i), dataOutRe, vecs[i].exp_dov ? re_of(vecs[i].exp_src) : 36'h0);
      check($sformatf("vec%0d_im", i), dataOutIm, vecs[i].exp_dov ? im_of(vecs[i].exp_src) : 36'h0);
    end
    start = 1'b0;
    check("bubble_stop", htStopDataInFlag, 1);
    check("bubble_done", done, 1);
    check("bubble_pulses", 128'(pulses - p0), 4);

    // Mid-frame reset after 10 acceptances
    reset = 1'b1;
    tick();
    reset = 1'b0;
    frameLength = 16'd20; start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready("midreset_ready_reached");
    sampleValid = 1'b1; sampleIn = 18'h00100;
    r = 0; n = 0;
    while (r < 10 && n < 100) begin
      if (sampleReady === 1'b1) r++;
      tick();
      sampleIn = sampleIn + 18'd1;
      n++;
    end
    check("midreset_accepts", 128'(r), 10);
    sampleValid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_outputs_zero", all_outs(), 0);
    p0 = pulses;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("midreset_quiet", 128'({dataOutValid, done, htEnable, busy}), 0);
    end
    check("midreset_no_pulses", 128'(pulses - p0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
